cong_tru_pipe: RTL and testbench
================================

CONG_TRU_PIPE -- requirements
Module: cong_tru_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter FRAC_W, default 23, meaning stored fraction width; word width W = 1+EXP_W+FRAC_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port A, input, W, IEEE-754-format operand A.
REQ-006 The block SHALL have port B, input, W, IEEE-754-format operand B.
REQ-007 The block SHALL have port check_pt, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-008 The block SHALL have port in_valid, input, 1, operands valid.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-010 The block SHALL have port result, output, W, rounded result.
REQ-011 The block SHALL have port out_valid, output, 1, result and flags valid.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 The block SHALL have ports overflow, underflow, inexact, invalid, each output, 1, exception flags qualified by out_valid.

Function
REQ-014 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-015 Pipeline SHALL be 3 registered stages, S1 (unpack, exponent compare, swap, align shift with guard/round/sticky), S2 (two's-complement add, sign of result), S3 (leading-one normalise, round, exponent adjust, special-case select, pack).
REQ-016 Latency SHALL be exactly 3 cycles from input transfer to out_valid when no stall; throughput one operation per cycle.
REQ-017 Global advance enable en = !out_valid || out_ready; in_ready = en; when en=0 all stage registers SHALL hold.
REQ-018 Each stage SHALL carry a valid bit; bubbles propagate as valid=0; results SHALL emerge in acceptance order with no loss or duplication.
REQ-019 Effective sign of B SHALL be B[W-1] XOR check_pt.
REQ-020 Exponent field 0 (zero/subnormal) SHALL be treated as signed zero (flush-to-zero) on input; subnormal results SHALL flush to signed zero with underflow=1.
REQ-021 Align shift amounts ≥ FRAC_W+3 SHALL collapse the smaller operand into sticky only.
REQ-022 Rounding SHALL be round-to-nearest-even on guard/round/sticky; inexact=1 whenever any discarded bit is 1; rounding carry-out SHALL renormalise and increment exponent.
REQ-023 Exact zero sum of opposite-sign operands SHALL give +0; -0 + -0 SHALL give -0.
REQ-024 Biased result exponent ≥ all-ones SHALL give signed infinity with overflow=1, inexact=1.
REQ-025 Any NaN input, or inf minus inf (effective), SHALL give canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0) with invalid=1 only for inf-minus-inf or signalling NaN.
REQ-026 Infinity with finite operand SHALL give that infinity, no flags.
REQ-027 All flags SHALL be 0 when out_valid=0.

Reset
REQ-028 While rst=1, all stage valid bits, out_valid, result and all flags SHALL be 0 immediately (asynchronous), in_ready SHALL be 1 after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; no output transfer for them after release.

Verification
REQ-030 A=0x3F800000, B=0x40000000, check_pt=0, out_ready=1 -> result 0x40400000 exactly 3 cycles later, flags 0.
REQ-031 A=0x3F800000, B=0x3F800000, check_pt=1 -> result 0x00000000, flags 0; A=0x3F800000, B=0x33800000 (2^-24), add -> 0x3F800000, inexact=1 (tie to even).
REQ-032 A=B=0x7F7FFFFF, add -> 0x7F800000, overflow=1, inexact=1; A=0x7F800000, B=0x7F800000, check_pt=1 -> 0x7FC00000, invalid=1.
REQ-033 Stream 6 back-to-back operations, out_ready held 0 for 5 cycles mid-stream -> in_ready=0 during stall, outputs held stable, all 6 results delivered in order, none dropped.
REQ-034 Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 immediately, no stale results after release, next accepted operation appears 3 cycles after acceptance.
REQ-035 Parameter run EXP_W=5, FRAC_W=10 (half precision): 0x3C00 + 0x4000 -> 0x4200; 0x7BFF + 0x7BFF -> 0x7C00, overflow=1.

Source files
------------

// File: rtl/cong_tru_pipe.sv
// Three-stage pipelined floating-point adder/subtractor for IEEE-754-format words.
// Inputs with a zero exponent field are flushed to signed zero, tiny results flush to zero,
// and rounding is round-to-nearest-even. A single advance enable stalls every stage together.
module cong_tru_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+FRAC_W:0]     A,
    input  logic [EXP_W+FRAC_W:0]     B,
    input  logic                      check_pt,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      inexact,
    output logic                      invalid
);
    localparam int unsigned W         = 1 + EXP_W + FRAC_W;
    localparam int unsigned MW        = FRAC_W + 4;              // hidden + fraction + G/R/S
    localparam int unsigned SW        = MW + 1;                  // sum with carry-out
    localparam int unsigned LZW       = $clog2(MW + 1);
    localparam int unsigned XW        = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam int unsigned SHIFT_MAX = FRAC_W + 3;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operand decode
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign a_sign = A[W-1];
    assign b_sign = B[W-1] ^ check_pt;
    assign a_exp  = A[W-2:FRAC_W];
    assign b_exp  = B[W-2:FRAC_W];
    assign a_frac = A[FRAC_W-1:0];
    assign b_frac = B[FRAC_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_MAX) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_MAX) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_MAX) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_MAX) && (b_frac != '0);
    assign a_snan = a_nan && !a_frac[FRAC_W-1];
    assign b_snan = b_nan && !b_frac[FRAC_W-1];

    logic             big_sign, sp_nan, sp_inv, sp_inf, sp_inf_sign;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic [FRAC_W:0]  big_mant, small_mant, a_mant, b_mant;
    logic [MW-1:0]    small_al;
    logic [2*MW-1:0]  shifted;

    // Swap so the larger magnitude is first, then align the smaller with sticky collection
    always_comb begin
        a_mant = a_zero ? '0 : {1'b1, a_frac};
        b_mant = b_zero ? '0 : {1'b1, b_frac};
        if ({b_exp, b_mant} > {a_exp, a_mant}) begin
            big_sign = b_sign; big_exp = b_exp; big_mant = b_mant;
            small_exp = b_zero ? b_exp : a_exp;
            small_exp = a_exp; small_mant = a_mant;
        end else begin
            big_sign = a_sign; big_exp = a_exp; big_mant = a_mant;
            small_exp = b_exp; small_mant = b_mant;
        end
        diff    = big_exp - small_exp;
        shifted = {small_mant, 3'b000, {MW{1'b0}}} >> diff;
        if (32'(diff) >= SHIFT_MAX) begin
            small_al = {{(MW-1){1'b0}}, |small_mant};
        end else begin
            small_al = shifted[2*MW-1:MW] | {{(MW-1){1'b0}}, |shifted[MW-1:0]};
        end
        sp_nan      = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
        sp_inv      = a_snan || b_snan || (a_inf && b_inf && (a_sign != b_sign));
        sp_inf      = !sp_nan && (a_inf || b_inf);
        sp_inf_sign = a_inf ? a_sign : b_sign;
    end

    logic             s1_valid, s1_sub, s1_sign, s1_nan, s1_inv, s1_inf, s1_inf_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_big, s1_small;

    // Stage 1 register: unpacked, swapped, aligned operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid    <= in_valid;
            s1_sub      <= a_sign ^ b_sign;
            s1_sign     <= big_sign;
            s1_exp      <= big_exp;
            s1_big      <= {big_mant, 3'b000};
            s1_small    <= small_al;
            s1_nan      <= sp_nan;
            s1_inv      <= sp_inv;
            s1_inf      <= sp_inf;
            s1_inf_sign <= sp_inf_sign;
        end
    end

    logic             s2_valid, s2_sub, s2_sign, s2_nan, s2_inv, s2_inf, s2_inf_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;

    // Stage 2 register: magnitude add/subtract; big >= small so the result is non-negative
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid    <= s1_valid;
            s2_sum      <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                                  : ({1'b0, s1_big} + {1'b0, s1_small});
            s2_sub      <= s1_sub;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_nan      <= s1_nan;
            s2_inv      <= s1_inv;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
        end
    end

    function automatic logic [LZW-1:0] lead_zeros(input logic [MW-1:0] v);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < MW; i++) begin
            if (v[i]) n = LZW'(MW - 1 - i);
        end
        return n;
    endfunction

    logic [MW-1:0]     norm;
    logic [LZW-1:0]    lz;
    logic [XW-1:0]     exp_n, exp_r;
    logic [FRAC_W+1:0] rounded;
    logic [FRAC_W-1:0] frac_r;
    logic              rnd_up, lost;
    logic [W-1:0]      res_d;
    logic              ovf_d, unf_d, inx_d, inv_d;

    // Normalise, round to nearest even, then select special/overflow/underflow encodings
    always_comb begin
        lz = '0;
        if (s2_sum[SW-1]) begin
            norm  = s2_sum[SW-1:1] | {{(MW-1){1'b0}}, s2_sum[0]};
            exp_n = XW'(s2_exp) + XW'(1);
        end else begin
            lz    = lead_zeros(s2_sum[MW-1:0]);
            norm  = s2_sum[MW-1:0] << lz;
            exp_n = XW'(s2_exp) - XW'(lz);
        end
        lost    = norm[2] | norm[1] | norm[0];
        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_up};
        exp_r   = rounded[FRAC_W+1] ? exp_n + XW'(1) : exp_n;
        frac_r  = rounded[FRAC_W+1] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        res_d = '0; ovf_d = 1'b0; unf_d = 1'b0; inx_d = 1'b0; inv_d = 1'b0;
        if (!s2_valid) begin
            res_d = '0;
        end else if (s2_nan) begin
            res_d = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
            inv_d = s2_inv;
        end else if (s2_inf) begin
            res_d = {s2_inf_sign, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (s2_sum == '0) begin
            // Cancellation gives +0; only like-signed zeros keep their sign
            res_d = {s2_sign & !s2_sub, {(W-1){1'b0}}};
        end else if (!exp_r[XW-1] && (exp_r >= XW'(EXP_MAX))) begin
            res_d = {s2_sign, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            res_d = {s2_sign, {(W-1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            res_d = {s2_sign, exp_r[EXP_W-1:0], frac_r};
            inx_d = lost;
        end
    end

    // Stage 3 register: packed result and flags, zero whenever the slot is a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            result    <= res_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            inexact   <= inx_d;
            invalid   <= inv_d;
        end
    end
endmodule

// File: tb/tb_cong_tru_pipe.sv
// Self-checking bench for cong_tru_pipe: single-precision and half-precision instances,
// expected values from hand-computed vectors pushed to a scoreboard at input acceptance.
module tb_cong_tru_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [31:0] op_a, op_b, res;
    logic op, iv, ir, ov, ordy, f_ovf, f_unf, f_inx, f_inv;
    logic [15:0] h_a, h_b, h_res;
    logic h_op, h_iv, h_ir, h_ov, h_ordy, h_ovf, h_unf, h_inx, h_inv;
    logic [3:0] flags, h_flags;
    assign flags   = {f_ovf, f_unf, f_inx, f_inv};
    assign h_flags = {h_ovf, h_unf, h_inx, h_inv};

    cong_tru_pipe dut (
        .clk(clk), .rst(rst), .A(op_a), .B(op_b), .check_pt(op), .in_valid(iv),
        .in_ready(ir), .result(res), .out_valid(ov), .out_ready(ordy),
        .overflow(f_ovf), .underflow(f_unf), .inexact(f_inx), .invalid(f_inv)
    );

    cong_tru_pipe #(.EXP_W(5), .FRAC_W(10)) dut_h (
        .clk(clk), .rst(rst), .A(h_a), .B(h_b), .check_pt(h_op), .in_valid(h_iv),
        .in_ready(h_ir), .result(h_res), .out_valid(h_ov), .out_ready(h_ordy),
        .overflow(h_ovf), .underflow(h_unf), .inexact(h_inx), .invalid(h_inv)
    );

    typedef struct {
        logic [31:0] a, b, r;
        logic        op;
        logic [3:0]  f;   // {overflow, underflow, inexact, invalid}
    } vec_t;

    vec_t        vecs[$];
    vec_t        hvecs[$];
    logic [35:0] sb[$];
    logic [35:0] hsb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic o,
                           input logic [31:0] r, input logic [3:0] f, input logic half);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.r = r; v.f = f;
        if (half) hvecs.push_back(v);
        else vecs.push_back(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; h_iv = 1'b0; h_ordy = 1'b1;
        op_a = '0; op_b = '0; op = 1'b0; h_a = '0; h_b = '0; h_op = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", ov); end
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", res); end
        n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
        n_cmp++; if (h_ov !== 1'b0) begin n_bad++; $display("FAIL reset_half_out_valid got=%b want=0", h_ov); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", ir); end
        n_cmp++; if (h_ir !== 1'b1) begin n_bad++; $display("FAIL reset_half_in_ready got=%b want=1", h_ir); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        op_a = 32'h3F800000; op_b = 32'h40000000; op = 1'b0; iv = 1'b1; ordy = 1'b1; #1;
        n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL latency_accept got=%b want=1", ir); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); iv = 1'b0; #1;
            if (c < 3) begin
                n_cmp++;
                if (ov !== 1'b0) begin n_bad++; $display("FAIL latency_early c=%0d got=%b want=0", c, ov); end
            end else begin
                n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL latency_valid got=%b want=1", ov); end
                n_cmp++; if (res !== 32'h40400000) begin n_bad++; $display("FAIL latency_result got=%h want=40400000", res); end
                n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL latency_flags got=%b want=0000", flags); end
            end
        end
    endtask

    task automatic test_vectors();
        logic [35:0] e;
        int idx = 0, got = 0, cyc = 0;
        sb.delete();
        while (got < vecs.size() && cyc < 400) begin
            @(negedge clk);
            ordy = ($urandom_range(0, 3) != 0);
            if (idx < vecs.size() && $urandom_range(0, 4) != 0) begin
                op_a = vecs[idx].a; op_b = vecs[idx].b; op = vecs[idx].op; iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            #1;
            if (ov === 1'b1 && ordy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL vec_unexpected got=%h want=no output", res);
                end else begin
                    e = sb.pop_front();
                    if (res !== e[35:4]) begin n_bad++; $display("FAIL vec_result n=%0d got=%h want=%h", got, res, e[35:4]); end
                    n_cmp++;
                    if (flags !== e[3:0]) begin n_bad++; $display("FAIL vec_flags n=%0d got=%b want=%b", got, flags, e[3:0]); end
                end
                got++;
            end
            if (iv && ir === 1'b1) begin
                sb.push_back({vecs[idx].r, vecs[idx].f});
                idx++;
            end
            cyc++;
        end
        iv = 1'b0; ordy = 1'b1;
        n_cmp++;
        if (got != vecs.size()) begin n_bad++; $display("FAIL vec_count got=%0d want=%0d", got, vecs.size()); end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        logic [31:0] held_res;
        logic [3:0]  held_f;
        logic        held_v = 1'b0;
        int idx = 0, got = 0, cyc = 0;
        sb.delete();
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            ordy = !(cyc >= 4 && cyc < 9);
            if (idx < 6) begin
                op_a = vecs[idx].a; op_b = vecs[idx].b; op = vecs[idx].op; iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            #1;
            if (held_v) begin
                n_cmp++;
                if (ov !== 1'b1 || res !== held_res || flags !== held_f) begin
                    n_bad++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", ov, res, flags, held_res, held_f);
                end
            end
            held_v = 1'b0;
            if (ov === 1'b1 && !ordy) begin
                n_cmp++;
                if (ir !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b want=0", ir); end
                held_res = res; held_f = flags; held_v = 1'b1;
            end
            if (ov === 1'b1 && ordy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL b2b_unexpected got=%h want=no output", res);
                end else begin
                    e = sb.pop_front();
                    if (res !== e[35:4] || flags !== e[3:0]) begin
                        n_bad++; $display("FAIL b2b_result n=%0d got=%h/%b want=%h/%b", got, res, flags, e[35:4], e[3:0]);
                    end
                end
                got++;
            end
            if (iv && ir === 1'b1) begin
                sb.push_back({vecs[idx].r, vecs[idx].f});
                idx++;
            end
            cyc++;
        end
        iv = 1'b0; ordy = 1'b1;
        n_cmp++;
        if (got != 6 || sb.size() != 0) begin n_bad++; $display("FAIL b2b_count got=%0d want=6", got); end
    endtask

    task automatic test_reset_in_flight();
        int lat = 0;
        logic seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op_a = vecs[k].a; op_b = vecs[k].b; op = vecs[k].op; iv = 1'b1; ordy = 1'b1;
        end
        @(negedge clk); iv = 1'b0; rst = 1'b1; #1;
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL rst_flight_valid got=%b want=0", ov); end
        n_cmp++; if (res !== 32'h0 || flags !== 4'h0) begin n_bad++; $display("FAIL rst_flight_data got=%h/%b want=0/0000", res, flags); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ov !== 1'b0) begin n_bad++; $display("FAIL rst_flight_stale c=%0d got=%b want=0", c, ov); end
        end
        @(negedge clk);
        op_a = 32'h40400000; op_b = 32'h3F800000; op = 1'b1; iv = 1'b1; #1;
        n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL rst_flight_accept got=%b want=1", ir); end
        while (!seen && lat < 10) begin
            @(negedge clk); iv = 1'b0; lat++; #1;
            if (ov === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (lat != 3 || !seen) begin n_bad++; $display("FAIL rst_flight_latency got=%0d want=3", lat); end
        n_cmp++; if (res !== 32'h40000000) begin n_bad++; $display("FAIL rst_flight_result got=%h want=40000000", res); end
    endtask

    task automatic test_half();
        logic [35:0] e;
        int idx = 0, got = 0, cyc = 0;
        hsb.delete();
        while (got < hvecs.size() && cyc < 100) begin
            @(negedge clk);
            h_ordy = 1'b1;
            if (idx < hvecs.size()) begin
                h_a = hvecs[idx].a[15:0]; h_b = hvecs[idx].b[15:0]; h_op = hvecs[idx].op; h_iv = 1'b1;
            end else begin
                h_iv = 1'b0;
            end
            #1;
            if (h_ov === 1'b1) begin
                n_cmp++;
                if (hsb.size() == 0) begin
                    n_bad++; $display("FAIL half_unexpected got=%h want=no output", h_res);
                end else begin
                    e = hsb.pop_front();
                    if (h_res !== e[19:4]) begin n_bad++; $display("FAIL half_result n=%0d got=%h want=%h", got, h_res, e[19:4]); end
                    n_cmp++;
                    if (h_flags !== e[3:0]) begin n_bad++; $display("FAIL half_flags n=%0d got=%b want=%b", got, h_flags, e[3:0]); end
                end
                got++;
            end
            if (h_iv && h_ir === 1'b1) begin
                hsb.push_back({hvecs[idx].r, hvecs[idx].f});
                idx++;
            end
            cyc++;
        end
        h_iv = 1'b0;
        n_cmp++;
        if (got != hvecs.size()) begin n_bad++; $display("FAIL half_count got=%0d want=%0d", got, hvecs.size()); end
    endtask

    initial begin
        // {overflow, underflow, inexact, invalid}
        add_vec(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
        add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, 1'b0);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010, 1'b0);
        add_vec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001, 1'b0);
        add_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1'b0);
        add_vec(32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 4'b0000, 1'b0);
        add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b0);
        add_vec(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000, 1'b0);
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1'b0);
        add_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 1'b0);
        add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b0);
        add_vec(32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0001, 1'b0);
        add_vec(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 1'b0);
        add_vec(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0110, 1'b0);
        add_vec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010, 1'b0);
        add_vec(32'h3F7FFFFF, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 1'b0);
        add_vec(32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0010, 1'b0);
        add_vec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0010, 1'b0);
        add_vec(32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 4'b0010, 1'b0);
        add_vec(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 1'b0);
        add_vec(32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
        add_vec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 1'b0);
        add_vec(32'h3C00, 32'h4000, 1'b0, 32'h4200, 4'b0000, 1'b1);
        add_vec(32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b1010, 1'b1);
        add_vec(32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'b0000, 1'b1);
        add_vec(32'h4200, 32'h3C00, 1'b1, 32'h4000, 4'b0000, 1'b1);
        add_vec(32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'b0010, 1'b1);
        add_vec(32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 4'b0001, 1'b1);

        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_half();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
